store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- M-stage store path of the P7 CPU; the write-side counterpart of the load data extender.
- Converts sw/sh/sb requests into a byte-enabled, lane-aligned bus write and detects the AdES exception.
- Posts accepted stores into a small write buffer that drains to the DM/peripheral bridge over a valid/ready handshake.
- Flags loads that hit a pending buffered store so the pipeline can stall them.

Parameters:
- DEPTH, 2, write-buffer entries (power of two, >=2).
- AW, 32, address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- st_valid  in  1  M-stage store request present.
- st_op  in  2  store type: 00 sw, 01 sh, 10 sb, 11 reserved (treated as no store).
- st_addr  in  AW  effective address.
- st_wdata  in  32  GPR data, low-aligned.
- st_overflow  in  1  address adder overflowed.
- st_ready  out  1  buffer can accept; equals !full.
- M_EXC_AdES  out  1  store address exception, combinational.
- m_data_addr  out  AW  word-aligned bus address ({addr[31:2],2'b00}).
- m_data_wdata  out  32  lane-replicated data.
- m_data_byteen  out  4  byte enables.
- m_wvalid  out  1  head entry valid.
- m_wready  in  1  bus accepts head.
- ld_addr  in  AW  address of the M-stage load.
- ld_valid  in  1  load present.
- ld_hazard  out  1  load word matches any pending entry.

Behaviour:
- Reset (asynchronous, active-low): buffer emptied; m_wvalid=0; m_data_addr, m_data_wdata and m_data_byteen=0; st_ready=1.
- Valid ranges: 0x0000-0x2fff (DM); 0x7f00-0x7f0b (timer0); 0x7f10-0x7f1b (timer1); 0x7f20-0x7f23 (interrupt generator).
- M_EXC_AdES = st_valid & st_op!=11 & any of the following:
  - sw with addr[1:0]!=0;
  - sh with addr[0]=1;
  - address outside every valid range;
  - sh/sb to any address >=0x7f00;
  - write to a timer COUNT register (0x7f08-0x7f0b or 0x7f18-0x7f1b);
  - st_overflow=1.
- Lane encoding:
  - sw: byteen 1111, wdata = st_wdata.
  - sh: byteen 0011 when addr[1]=0, 1100 when addr[1]=1; wdata = {2{st_wdata[15:0]}}.
  - sb: byteen = 0001 << addr[1:0]; wdata = {4{st_wdata[7:0]}}.
- Push: on a clk edge when st_valid & st_op!=11 & !AdES & st_ready. Faulting or reserved requests are never enqueued.
- Pop: on a clk edge when m_wvalid & m_wready. The head advances and the next entry appears the following cycle.
- Push and pop in the same cycle with not-full: both happen; occupancy is unchanged.
- Full: st_ready=0 regardless of m_wready (no combinational ready path from bus to pipeline). The pipeline holds the store.
- Latency: a store accepted at edge N is presented on the bus in cycle N+1 at the earliest (no-bypass build).
- Bus outputs remain stable while m_wvalid=1 and m_wready=0.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Empty when pointers are equal; full when indices match and MSBs differ.
- ld_hazard = ld_valid & (some valid entry has addr[31:2] == ld_addr[31:2]). Combinational; computed over entries only, not the incoming store.
- Reset asserted mid-drain: pending entries are discarded and m_wvalid drops asynchronously.

Optional Feature:
- Macro: STORE_UNIT_BYPASS_EN.
- Defined: when the buffer is empty, the bus outputs are driven combinationally from the incoming legal store. If m_wready=1 the same cycle, the store completes with no enqueue (zero latency); otherwise it is enqueued normally. ld_hazard is unchanged.
- Undefined: the bus is always fed from registered buffer entries (1-cycle minimum latency).

Decomposition:
- Shared package (cpu_pkg): store opcode constants (ST_SW/ST_SH/ST_SB); address-map base/limit constants; timer COUNT offset.
- One sub-module: store_fifo (generic DEPTH×(AW+36) buffer with push/pop, full/empty, and per-entry valid/address exposure for hazard compare).
- Lane encoding and AdES logic stay in the top.

Test Plan:
- sb to 0x0000_1003 with data 0x0000_00A5, m_wready=1 -> one cycle later: m_data_addr=0x1000, byteen=1000, wdata=0xA5A5A5A5, m_wvalid=1 for one cycle.
- sh to 0x0000_0002 / sw to 0x0000_0006 / sb to 0x7f04 / sw to 0x7f08 / sw to 0x3000 -> sh accepted with byteen=1100; the other four raise AdES and nothing is enqueued.
- m_wready=0, three back-to-back sw (DEPTH=2) -> st_ready falls after the 2nd push; the 3rd is held; raising m_wready drains in order with addresses preserved.
- Pending sw to 0x0000_0010; load from 0x0000_0013 -> ld_hazard=1; load from 0x0000_0014 -> ld_hazard=0.
- Buffer holding 2 entries; assert reset low mid-drain -> m_wvalid=0 immediately, st_ready=1 after release, no stale write issued.
- STORE_UNIT_BYPASS_EN defined, buffer empty, m_wready=1, sw 0x0000_0020 -> bus write in the same cycle, buffer stays empty.

Source files
------------

// File: rtl/store_unit_pkg.sv
// store_unit_pkg: store opcodes and the P7 address map shared by the store path.
package store_unit_pkg;
  localparam logic [1:0] ST_SW = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SB = 2'b10;
  localparam logic [1:0] ST_NONE = 2'b11;
  localparam logic [31:0] DM_LIMIT = 32'h0000_2fff;
  localparam logic [31:0] IO_BASE = 32'h0000_7f00;
  localparam logic [31:0] TMR0_BASE = 32'h0000_7f00;
  localparam logic [31:0] TMR1_BASE = 32'h0000_7f10;
  localparam logic [31:0] IRQ_BASE = 32'h0000_7f20;
  localparam logic [31:0] TMR_SPAN = 32'd12;
  localparam logic [31:0] IRQ_SPAN = 32'd4;
  localparam logic [31:0] TMR_COUNT = 32'd8;
  function automatic logic in_win(logic [31:0] a, logic [31:0] base, logic [31:0] span);
    return a >= base && a < base + span;
  endfunction
endpackage

// File: rtl/store_unit_fifo.sv
// store_fifo: DEPTH-entry write buffer exposing per-entry valid and address for hazard checks.
module store_fifo #(
  parameter int DEPTH = 2,
  parameter int AW = 32,
  parameter int W = AW + 36
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [W-1:0]                din,
  output logic [W-1:0]                head,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0]            ent_valid,
  output logic [DEPTH-1:0][AW-1:0]    ent_addr
);
  localparam int L = $clog2(DEPTH);
  logic [L:0] wp, rp, cnt;
  logic [DEPTH-1:0][W-1:0] mem;
  assign empty = wp == rp;
  assign full = wp[L-1:0] == rp[L-1:0] && wp[L] != rp[L];
  assign head = mem[rp[L-1:0]];
  assign cnt = wp - rp;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (L+1)'(1);
      if (pop) rp <= rp + (L+1)'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wp[L-1:0]] <= din;
  // an entry is live when its distance past the read index is below occupancy
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [L-1:0] off;
    assign off = L'(i) - rp[L-1:0];
    assign ent_valid[i] = {1'b0, off} < cnt;
    assign ent_addr[i] = mem[i][W-1 -: AW];
  end
endmodule

// File: rtl/store_unit.sv
// store_unit: M-stage store lane encoding, AdES detection and posted write buffer.
// STORE_UNIT_BYPASS_EN: drive the bus straight from a legal store while the buffer is empty.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [1:0]    st_op,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_wdata,
  input  logic          st_overflow,
  output logic          st_ready,
  output logic          M_EXC_AdES,
  output logic [AW-1:0] m_data_addr,
  output logic [31:0]   m_data_wdata,
  output logic [3:0]    m_data_byteen,
  output logic          m_wvalid,
  input  logic          m_wready,
  input  logic [AW-1:0] ld_addr,
  input  logic          ld_valid,
  output logic          ld_hazard
);
  localparam int W = AW + 36;
  logic [31:0] a, wd;
  logic [3:0] be;
  logic is_sw, is_sh, req, in_range, is_count, ades, legal, push, pop, full, empty;
  logic [W-1:0] din, head, bus;
  logic [DEPTH-1:0] ent_valid, hit;
  logic [DEPTH-1:0][AW-1:0] ent_addr;
  assign a = 32'(st_addr);
  assign is_sw = st_op == ST_SW;
  assign is_sh = st_op == ST_SH;
  assign req = st_valid && st_op != ST_NONE;
  assign in_range = a <= DM_LIMIT || in_win(a, TMR0_BASE, TMR_SPAN) ||
                    in_win(a, TMR1_BASE, TMR_SPAN) || in_win(a, IRQ_BASE, IRQ_SPAN);
  assign is_count = in_win(a, TMR0_BASE + TMR_COUNT, 32'd4) || in_win(a, TMR1_BASE + TMR_COUNT, 32'd4);
  assign ades = req && ((is_sw && a[1:0] != 2'b00) || (is_sh && a[0]) || !in_range ||
                        (!is_sw && a >= IO_BASE) || is_count || st_overflow);
  assign M_EXC_AdES = ades;
  assign legal = req && !ades;
  assign be = is_sw ? 4'b1111 : is_sh ? (a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a[1:0];
  assign wd = is_sw ? st_wdata : is_sh ? {2{st_wdata[15:0]}} : {4{st_wdata[7:0]}};
  assign din = {st_addr[AW-1:2], 2'b00, wd, be};
  assign st_ready = !full;
  assign pop = !empty && m_wready;
`ifdef STORE_UNIT_BYPASS_EN
  logic byp;
  assign byp = legal && empty;
  assign push = legal && !full && !(byp && m_wready);
  assign m_wvalid = !empty || byp;
  assign bus = !empty ? head : byp ? din : '0;
`else
  assign push = legal && !full;
  assign m_wvalid = !empty;
  assign bus = empty ? '0 : head;
`endif
  assign {m_data_addr, m_data_wdata, m_data_byteen} = bus;
  store_fifo #(.DEPTH(DEPTH), .AW(AW), .W(W)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .head(head),
    .full(full), .empty(empty), .ent_valid(ent_valid), .ent_addr(ent_addr)
  );
  // word match: xor then ignore the byte-offset bits
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit[i] = ent_valid[i] && ((ent_addr[i] ^ ld_addr) & ~AW'(3)) == '0;
  end
  assign ld_hazard = ld_valid && |hit;
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: randomized store traffic checked by a queue-based write-buffer model.
module tb_store_unit;
  localparam int DEPTH = 2;
`ifdef STORE_UNIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct packed {logic [31:0] addr; logic [31:0] data; logic [3:0] be;} wr_t;
  logic clk = 0, reset = 0;
  logic st_valid = 0, st_overflow = 0, m_wready = 0, ld_valid = 0;
  logic [1:0] st_op = 0;
  logic [31:0] st_addr = 0, st_wdata = 0, ld_addr = 0;
  logic st_ready, M_EXC_AdES, m_wvalid, ld_hazard;
  logic [31:0] m_data_addr, m_data_wdata;
  logic [3:0] m_data_byteen;
  int checks = 0, errors = 0;
  wr_t q[$];

  store_unit #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr),
    .st_wdata(st_wdata), .st_overflow(st_overflow), .st_ready(st_ready), .M_EXC_AdES(M_EXC_AdES),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .ld_addr(ld_addr), .ld_valid(ld_valid), .ld_hazard(ld_hazard)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_ades(logic [1:0] op, logic [31:0] a, bit ovf);
    bit mapped = (a < 32'h3000) || (a >= 32'h7f00 && a < 32'h7f0c) ||
                 (a >= 32'h7f10 && a < 32'h7f1c) || (a >= 32'h7f20 && a < 32'h7f24);
    bit count = (a >= 32'h7f08 && a < 32'h7f0c) || (a >= 32'h7f18 && a < 32'h7f1c);
    if (op == 2'b11) return 1'b0;
    return (op == 2'b00 && a % 4 != 0) || (op == 2'b01 && a % 2 != 0) || !mapped ||
           (op != 2'b00 && a >= 32'h7f00) || count || ovf;
  endfunction

  function automatic wr_t ref_wr(logic [1:0] op, logic [31:0] a, logic [31:0] d);
    int size = op == 2'b00 ? 4 : op == 2'b01 ? 2 : 1;
    int lane = int'(a % 4) / size * size;
    wr_t w;
    w.addr = a / 4 * 4;
    w.be = 4'(((1 << size) - 1) << lane);
    for (int k = 0; k < 4; k++) w.data[8*k +: 8] = d[8*(k % size) +: 8];
    return w;
  endfunction

  // model and monitor: compare the current cycle, then apply the coming edge to the queue
  always @(negedge clk) begin
    bit req, legal, full, haz, byp, exp_valid;
    wr_t h;
    if (!reset) begin
      q.delete();
      chk("rst_wvalid", m_wvalid, 0);
      chk("rst_ready", st_ready, 1);
      chk("rst_bus", {m_data_addr, m_data_wdata, m_data_byteen}, 0);
    end else begin
      req = st_valid && st_op != 2'b11;
      legal = req && !ref_ades(st_op, st_addr, st_overflow);
      full = q.size() == DEPTH;
      chk("ades", M_EXC_AdES, req && !legal);
      chk("st_ready", st_ready, !full);
      haz = 0;
      foreach (q[i]) if (q[i].addr / 4 == ld_addr / 4) haz = 1;
      chk("ld_hazard", ld_hazard, ld_valid && haz);
      byp = BYP && q.size() == 0 && legal;
      exp_valid = q.size() > 0 || byp;
      chk("m_wvalid", m_wvalid, exp_valid);
      if (exp_valid) begin
        h = q.size() > 0 ? q[0] : ref_wr(st_op, st_addr, st_wdata);
        chk("bus_addr", m_data_addr, h.addr);
        chk("bus_wdata", m_data_wdata, h.data);
        chk("bus_byteen", m_data_byteen, h.be);
        if (m_wready && q.size() > 0) void'(q.pop_front());
      end
      if (legal && !full && !(byp && m_wready)) q.push_back(ref_wr(st_op, st_addr, st_wdata));
    end
  end

  task automatic drive(bit v, logic [1:0] op, logic [31:0] a, logic [31:0] d, bit wr,
                       bit lv = 0, logic [31:0] la = 0);
    st_valid = v; st_op = op; st_addr = a; st_wdata = d; st_overflow = 0;
    m_wready = wr; ld_valid = lv; ld_addr = la;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    drive(1, 2'b10, 32'h1003, 32'h0000_00a5, 1);
    drive(0, 2'b00, 0, 0, 1);
    drive(1, 2'b01, 32'h0002, 32'h1234_beef, 1);
    drive(1, 2'b00, 32'h0006, 32'h1111_1111, 1);
    drive(1, 2'b10, 32'h7f04, 32'h2222_2222, 1);
    drive(1, 2'b00, 32'h7f08, 32'h3333_3333, 1);
    drive(1, 2'b00, 32'h3000, 32'h4444_4444, 1);
    drive(0, 2'b00, 0, 0, 1);
    drive(1, 2'b00, 32'h0100, 32'haaaa_0001, 0);
    drive(1, 2'b00, 32'h0104, 32'haaaa_0002, 0);
    chk("full_ready", st_ready, 0);
    drive(1, 2'b00, 32'h0108, 32'haaaa_0003, 0);
    drive(1, 2'b00, 32'h0108, 32'haaaa_0003, 1);
    drive(1, 2'b00, 32'h0108, 32'haaaa_0003, 1);
    drive(0, 2'b00, 0, 0, 1);
    drive(0, 2'b00, 0, 0, 1);
    drive(1, 2'b00, 32'h0010, 32'h5, 0);
    drive(0, 2'b00, 0, 0, 0, 1, 32'h0013);
    drive(0, 2'b00, 0, 0, 0, 1, 32'h0014);
    drive(0, 2'b00, 0, 0, 1);
    drive(0, 2'b00, 0, 0, 1);
    drive(1, 2'b00, 32'h0020, 32'h1, 0);
    drive(1, 2'b00, 32'h0024, 32'h2, 0);
    drive(0, 2'b00, 0, 0, 1);
    #2 reset = 0;
    #1 chk("async_wvalid", m_wvalid, 0);
    chk("async_ready", st_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    repeat (3) drive(0, 2'b00, 0, 0, 1);
    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 5))
        0: a = $urandom_range(0, 32'h2fff);
        1: a = 32'h7f00 + $urandom_range(0, 47);
        2: a = $urandom_range(32'h2ff0, 32'h3010);
        3, 4: a = $urandom_range(0, 63);
        default: a = $urandom;
      endcase
      st_valid = $urandom_range(0, 3) != 0;
      st_op = 2'($urandom_range(0, 3));
      st_addr = a;
      st_wdata = $urandom;
      st_overflow = $urandom_range(0, 15) == 0;
      m_wready = $urandom_range(0, 2) != 0;
      ld_valid = $urandom_range(0, 1) != 0;
      ld_addr = $urandom_range(0, 1) != 0 ? a : $urandom_range(0, 63);
      @(posedge clk); #1;
    end
    repeat (DEPTH + 3) drive(0, 2'b00, 0, 0, 1);
    chk("drained_wvalid", m_wvalid, 0);
    chk("drained_ready", st_ready, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
